// File: rtl/bit_unshift.sv
// bit_unshift: pipelined, runtime-programmable inverse of bit_shift.
//
// Moves a word opposite to a bit_shift instance built with the same
// SHIFT_DIRECTION/WRAP. One barrel stage per shift_amt bit; stage k moves
// by 2^k positions when its control bit is set. Valid, remaining control
// bits and (optionally) a discard bit travel alongside the word.
//
// Optional feature: define BIT_UNSHIFT_LOST_EN to build per-stage discard
// tracking and the sticky `lost` flag with its `clr_lost` clear. Without it
// `lost` is tied low and `clr_lost` is ignored; the port list is unchanged.
module bit_unshift #(
  parameter int DATA_WIDTH      = 8,
  parameter int SHIFT_WIDTH     = 3,
  parameter int SHIFT_DIRECTION = 0,
  parameter int WRAP            = 0,
  parameter int ARITHMETIC      = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [SHIFT_WIDTH-1:0] shift_amt,
  input  logic                   clr_lost,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   lost
);

  // ---------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------
  if (SHIFT_WIDTH < 1) begin : g_bad_shift_width
    $error("bit_unshift: SHIFT_WIDTH must be at least 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("bit_unshift: DATA_WIDTH must be at least 1");
  end
  if (SHIFT_DIRECTION != 0 && SHIFT_DIRECTION != 1) begin : g_bad_direction
    $error("bit_unshift: SHIFT_DIRECTION must be 0 or 1");
  end
  if (WRAP != 0 && WRAP != 1) begin : g_bad_wrap
    $error("bit_unshift: WRAP must be 0 or 1");
  end

  // Undoing a forward shift of direction 0 means moving right here.
  localparam bit SHIFT_RIGHT = (SHIFT_DIRECTION == 0);
  localparam bit ROTATE      = (WRAP != 0);
  // Sign fill only makes sense for a non-rotating right shift.
  localparam bit ARITH_FILL  = (ARITHMETIC != 0) && !ROTATE && SHIFT_RIGHT;
  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  // 2^k mod m without overflowing for large k (rotation distance of stage k).
  function automatic int pow2_mod(input int k, input int m);
    int r;
    r = 1 % m;
    for (int i = 0; i < k; i++) begin
      r = (r * 2) % m;
    end
    return r;
  endfunction

  // Stage distance for fill shifts; anything >= DATA_WIDTH empties the word.
  function automatic int clamp_step(input int k);
    if (k >= 30) begin
      return DATA_WIDTH;
    end
    if ((1 << k) >= DATA_WIDTH) begin
      return DATA_WIDTH;
    end
    return (1 << k);
  endfunction

  // Move a word by `step` positions in the configured direction.
  // Rotation callers pass step < DATA_WIDTH; fill callers pass step <= DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] move_word(
    input logic [DATA_WIDTH-1:0] w,
    input int                    step
  );
    logic [DATA_WIDTH-1:0] r;
    logic                  fill;
    fill = ARITH_FILL ? w[DATA_WIDTH-1] : 1'b0;
    if (ROTATE) begin
      if (SHIFT_RIGHT) begin
        r = (w >> step) | (w << (DATA_WIDTH - step));
      end else begin
        r = (w << step) | (w >> (DATA_WIDTH - step));
      end
    end else begin
      if (SHIFT_RIGHT) begin
        r = (w >> step) | (fill ? ~(ONES >> step) : '0);
      end else begin
        r = w << step;
      end
    end
    return r;
  endfunction

  // OR of the bits that a fill shift of `step` pushes off the edge.
  function automatic logic dropped_bits(
    input logic [DATA_WIDTH-1:0] w,
    input int                    step
  );
    logic [DATA_WIDTH-1:0] mask;
    if (SHIFT_RIGHT) begin
      mask = ~(ONES << step);
    end else begin
      mask = ~(ONES >> step);
    end
    return |(w & mask);
  endfunction

  // ---------------------------------------------------------------------
  // Barrel stages
  // ---------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < SHIFT_WIDTH; gi++) begin : g_stage
    // Control bits still needed by the stages after this one.
    localparam int REM  = SHIFT_WIDTH - 1 - gi;
    localparam int STEP = ROTATE ? pow2_mod(gi, DATA_WIDTH) : clamp_step(gi);

    logic [DATA_WIDTH-1:0]    word_in;
    logic [SHIFT_WIDTH-gi-1:0] amt_in;   // bit 0 controls this stage
    logic                      valid_in;
    logic [DATA_WIDTH-1:0]    word_next;
    logic [DATA_WIDTH-1:0]    word_reg;
    logic                      valid_reg;

    if (gi == 0) begin : g_src
      assign word_in  = data_in;
      assign amt_in   = shift_amt;
      assign valid_in = in_valid;
    end else begin : g_src
      assign word_in  = g_stage[gi-1].word_reg;
      assign amt_in   = g_stage[gi-1].g_rem.amt_reg;
      assign valid_in = g_stage[gi-1].valid_reg;
    end

    assign word_next = amt_in[0] ? move_word(word_in, STEP) : word_in;

    // Word and valid advance every cycle; bubbles travel as valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        word_reg  <= word_next;
        valid_reg <= valid_in;
      end
    end

    if (REM > 0) begin : g_rem
      logic [REM-1:0] amt_reg;
      // Drop the consumed control bit and hand the rest to the next stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amt_reg <= '0;
        end else begin
          amt_reg <= amt_in[REM:1];
        end
      end
    end

`ifdef BIT_UNSHIFT_LOST_EN
    logic disc_in;
    logic disc_step;
    logic disc_reg;

    if (gi == 0) begin : g_disc_src
      assign disc_in = 1'b0;
    end else begin : g_disc_src
      assign disc_in = g_stage[gi-1].disc_reg;
    end

    // Rotation never loses bits; fill shifts lose whatever falls off the edge.
    assign disc_step = !ROTATE && amt_in[0] && dropped_bits(word_in, STEP);

    // Accumulate the discard indication alongside the word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        disc_reg <= 1'b0;
      end else begin
        disc_reg <= disc_in | disc_step;
      end
    end
`endif
  end

  assign out_valid = g_stage[SHIFT_WIDTH-1].valid_reg;
  assign data_out  = g_stage[SHIFT_WIDTH-1].word_reg;

  // ---------------------------------------------------------------------
  // Sticky lost flag
  // ---------------------------------------------------------------------
`ifdef BIT_UNSHIFT_LOST_EN
  logic lost_reg;

  // Set on a valid output that carried discarded bits; a set beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_reg <= 1'b0;
    end else if (out_valid && g_stage[SHIFT_WIDTH-1].disc_reg) begin
      lost_reg <= 1'b1;
    end else if (clr_lost) begin
      lost_reg <= 1'b0;
    end
  end

  assign lost = lost_reg;
`else
  logic unused_clr_lost;

  assign unused_clr_lost = clr_lost;
  assign lost            = 1'b0;
`endif

endmodule
